// File: rtl/common.sv
// Shared MEM-stage types: WB control bundle, load/store funct3 encodings, FSM states.
package common;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } control_type;

    // Stores reuse 000/001/010 for SB/SH/SW.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_funct3_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Unused funct3 codes fall into the word class, matching LW behaviour.
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: access_size = SZ_BYTE;
            3'b001, 3'b101: access_size = SZ_HALF;
            default:        access_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM, DEPTH x 32, byte write enables, read-first.
module data_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_stage.sv
// MEM stage: data RAM access with configurable wait states and a registered MEM/WB result.
// Define MISALIGN_TRAP_EN to flag and suppress misaligned half/word accesses.
module data_memory_stage
    import common::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        flush,
    input  logic [31:0] alu_result,
    input  logic [31:0] write_data,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  control_type control_in,
    input  logic [4:0]  rd_in,
    output logic        valid_out,
    output logic [31:0] memory_bypass,
    output logic [31:0] memory_output,
    output control_type control_out,
    output logic [4:0]  rd_out,
    output logic        stall,
    output logic        misaligned
);

    localparam int ADDR_W = $clog2(DEPTH);

    mem_state_t  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_req_addr, r_req_wdata;
    logic        r_req_we, r_req_re;
    logic [2:0]  r_req_f3;
    control_type r_req_ctrl;
    logic [4:0]  r_req_rd;

    logic        r_valid, r_mis, r_load_ok;
    logic [31:0] r_bypass;
    control_type r_ctrl;
    logic [4:0]  r_rd;
    logic [1:0]  r_lane;
    logic [2:0]  r_f3;

    logic        w_busy, w_mem_in, w_accept, w_done;
    logic [31:0] w_addr, w_wdata, w_ram_wdata, w_rdata, w_load_data;
    logic        w_we, w_re, w_store, w_load, w_mis;
    logic [2:0]  w_f3;
    control_type w_ctrl;
    logic [4:0]  w_rd;
    logic [1:0]  w_size, w_lane;
    logic [3:0]  w_be, w_ram_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_busy   = (r_state == BUSY);
    assign w_mem_in = MemRead | MemWrite;
    assign w_accept = !w_busy && valid_in && !flush;
    // flush beats both a new request and a pending completion.
    assign w_done   = !flush && (w_busy ? (r_cnt == 4'd1)
                                        : (valid_in && (!w_mem_in || WAIT_STATES == 0)));

    assign w_addr  = w_busy ? r_req_addr  : alu_result;
    assign w_wdata = w_busy ? r_req_wdata : write_data;
    assign w_we    = w_busy ? r_req_we    : MemWrite;
    assign w_re    = w_busy ? r_req_re    : MemRead;
    assign w_f3    = w_busy ? r_req_f3    : funct3;
    assign w_ctrl  = w_busy ? r_req_ctrl  : control_in;
    assign w_rd    = w_busy ? r_req_rd    : rd_in;

    assign w_store = w_we;
    assign w_load  = w_re && !w_we;
    assign w_size  = access_size(w_f3);

`ifdef MISALIGN_TRAP_EN
    assign w_mis = (w_store || w_load) &&
                   (((w_size == SZ_HALF) && w_addr[0]) ||
                    ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00)));
`else
    assign w_mis = 1'b0;
`endif

    // Lane is truncated to the access alignment.
    always_comb begin
        w_lane      = 2'b00;
        w_be        = 4'b1111;
        w_ram_wdata = w_wdata;
        case (w_size)
            SZ_BYTE: begin
                w_lane      = w_addr[1:0];
                w_be        = 4'b0001 << w_addr[1:0];
                w_ram_wdata = {4{w_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_lane      = {w_addr[1], 1'b0};
                w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
                w_ram_wdata = {2{w_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_ram_be = (w_store && !w_mis) ? w_be : 4'b0000;

    data_ram #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_data_ram (
        .clk    (clk),
        .i_en   (w_done),
        .i_be   (w_ram_be),
        .i_addr (w_addr[ADDR_W+1:2]),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_rdata)
    );

    always_comb begin
        w_byte      = w_rdata[{r_lane, 3'b000} +: 8];
        w_half      = r_lane[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_load_data = w_rdata;
        case (mem_funct3_t'(r_f3))
            LB:      w_load_data = {{24{w_byte[7]}}, w_byte};
            LBU:     w_load_data = {24'b0, w_byte};
            LH:      w_load_data = {{16{w_half[15]}}, w_half};
            LHU:     w_load_data = {16'b0, w_half};
            default: ;
        endcase
        if (!r_load_ok) begin
            w_load_data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_req_we    <= 1'b0;
            r_req_re    <= 1'b0;
            r_req_f3    <= '0;
            r_req_ctrl  <= '0;
            r_req_rd    <= '0;
            r_valid     <= 1'b0;
            r_bypass    <= '0;
            r_ctrl      <= '0;
            r_rd        <= '0;
            r_mis       <= 1'b0;
            r_load_ok   <= 1'b0;
            r_lane      <= '0;
            r_f3        <= '0;
        end else begin
            r_valid <= w_done;
            if (w_done) begin
                r_bypass  <= w_addr;
                r_ctrl    <= w_ctrl;
                r_rd      <= w_rd;
                r_mis     <= w_mis;
                r_load_ok <= w_load && !w_mis;
                r_lane    <= w_lane;
                r_f3      <= w_f3;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept && w_mem_in && WAIT_STATES != 0) begin
                        r_state     <= BUSY;
                        r_cnt       <= 4'(WAIT_STATES);
                        r_req_addr  <= alu_result;
                        r_req_wdata <= write_data;
                        r_req_we    <= MemWrite;
                        r_req_re    <= MemRead;
                        r_req_f3    <= funct3;
                        r_req_ctrl  <= control_in;
                        r_req_rd    <= rd_in;
                    end
                end
                BUSY: begin
                    if (flush || r_cnt == 4'd1) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall         = w_busy;
    assign valid_out     = r_valid;
    assign memory_bypass = r_bypass;
    assign memory_output = w_load_data;
    assign control_out   = r_ctrl;
    assign rd_out        = r_rd;
    assign misaligned    = r_mis;

endmodule

// File: tb/tb_data_memory_stage.sv
// Scoreboard bench for data_memory_stage: one instance with no wait states, one with three.
module tb_data_memory_stage;
    import common::*;

    localparam int NDUT = 2;

    typedef struct {
        logic [31:0] byp;
        logic [31:0] mout;
        logic [1:0]  ctrl;
        logic [4:0]  rd;
        logic        mis;
        int          done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vin  [NDUT];
    logic        fl   [NDUT];
    logic [31:0] addr [NDUT];
    logic [31:0] wd   [NDUT];
    logic        mw   [NDUT];
    logic        mr   [NDUT];
    logic [2:0]  f3   [NDUT];
    control_type ci   [NDUT];
    logic [4:0]  rdi  [NDUT];
    logic        vo   [NDUT];
    logic [31:0] byp  [NDUT];
    logic [31:0] mo   [NDUT];
    control_type co   [NDUT];
    logic [4:0]  rdo  [NDUT];
    logic        st   [NDUT];
    logic        mis  [NDUT];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] mm [NDUT][4096];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_stage #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst_n), .valid_in(vin[0]), .flush(fl[0]), .alu_result(addr[0]),
        .write_data(wd[0]), .MemWrite(mw[0]), .MemRead(mr[0]), .funct3(f3[0]),
        .control_in(ci[0]), .rd_in(rdi[0]), .valid_out(vo[0]), .memory_bypass(byp[0]),
        .memory_output(mo[0]), .control_out(co[0]), .rd_out(rdo[0]), .stall(st[0]),
        .misaligned(mis[0])
    );

    data_memory_stage #(.DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst_n), .valid_in(vin[1]), .flush(fl[1]), .alu_result(addr[1]),
        .write_data(wd[1]), .MemWrite(mw[1]), .MemRead(mr[1]), .funct3(f3[1]),
        .control_in(ci[1]), .rd_in(rdi[1]), .valid_out(vo[1]), .memory_bypass(byp[1]),
        .memory_output(mo[1]), .control_out(co[1]), .rd_out(rdo[1]), .stall(st[1]),
        .misaligned(mis[1])
    );

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Byte-array reference: memory is 4096 bytes, so addresses wrap naturally.
    task automatic model_op(input int k, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic r, input logic [2:0] f,
                            output logic [31:0] mout, output logic m);
        int b, sz;
        logic [31:0] v;
        b  = int'(a[11:0]);
        sz = (f == 3'b000 || f == 3'b100) ? 1 : (f == 3'b001 || f == 3'b101) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
        m = (w || r) && (b % sz != 0);
`else
        m = 1'b0;
`endif
        b    = b - (b % sz);
        mout = '0;
        if (w && !m) begin
            for (int i = 0; i < sz; i++) mm[k][b+i] = d[8*i +: 8];
        end else if (r && !m) begin
            v = '0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[k][b+i];
            case (f)
                3'b000:  mout = {{24{v[7]}}, v[7:0]};
                3'b001:  mout = {{16{v[15]}}, v[15:0]};
                3'b100:  mout = {24'b0, v[7:0]};
                3'b101:  mout = {16'b0, v[15:0]};
                default: mout = v;
            endcase
        end
    endtask

    task automatic idle_inputs(input int k);
        vin[k] = 1'b0; fl[k] = 1'b0; mw[k] = 1'b0; mr[k] = 1'b0;
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic r, input logic [2:0] f, input logic [4:0] rdv);
        exp_t e;
        int   guard;
        guard = 0;
        @(posedge clk); #1;
        while (st[k] && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (st[k]) check("stall_timeout", 32'd1, 32'd0);
        vin[k] = 1'b1; addr[k] = a; wd[k] = d; mw[k] = w; mr[k] = r; f3[k] = f;
        rdi[k] = rdv; ci[k] = control_type'(rdv[1:0]);
        model_op(k, a, d, w, r, f, e.mout, e.mis);
        e.byp  = a;
        e.ctrl = rdv[1:0];
        e.rd   = rdv;
        e.done = cyc + 1 + ((w || r) ? ws(k) : 0);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk); #1;
        idle_inputs(k);
    endtask

    task automatic drain(input int k);
        int guard;
        guard = 0;
        while (((k == 0) ? q0.size() : q1.size()) != 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        if (((k == 0) ? q0.size() : q1.size()) != 0) check("drain_timeout", 32'd1, 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int k = 0; k < NDUT; k++) begin
            if (rst_n && vo[k]) begin
                if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("spurious_valid%0d", k), 32'd1, 32'd0);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("latency%0d", k), 32'(cyc), 32'(e.done));
                    check($sformatf("bypass%0d", k), byp[k], e.byp);
                    check($sformatf("mem_out%0d", k), mo[k], e.mout);
                    check($sformatf("ctrl%0d", k), 32'(co[k]), 32'(e.ctrl));
                    check($sformatf("rd%0d", k), 32'(rdo[k]), 32'(e.rd));
                    check($sformatf("misaligned%0d", k), 32'(mis[k]), 32'(e.mis));
                end
            end
            if (rst_n && k == 0 && st[0]) check("stall_ws0", 32'd1, 32'd0);
        end
    end

    task automatic check_reset_outputs(input int k, input string tag);
        check({tag, "_valid"}, 32'(vo[k]), 32'd0);
        check({tag, "_bypass"}, byp[k], 32'd0);
        check({tag, "_mem_out"}, mo[k], 32'd0);
        check({tag, "_rd"}, 32'(rdo[k]), 32'd0);
        check({tag, "_ctrl"}, 32'(co[k]), 32'd0);
        check({tag, "_stall"}, 32'(st[k]), 32'd0);
        check({tag, "_mis"}, 32'(mis[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            idle_inputs(k);
            addr[k] = '0; wd[k] = '0; f3[k] = '0; ci[k] = '0; rdi[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(0, "rst0");
        check_reset_outputs(1, "rst1");
        rst_n = 1'b1;

        // No wait states: store/load, byte lanes, extension, aliasing, both-flag store.
        issue(0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 3'b010, 5'd1);
        issue(0, 32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 5'd2);
        issue(0, 32'h20, 32'h44332211, 1'b1, 1'b0, 3'b010, 5'd3);
        issue(0, 32'h21, 32'h00000080, 1'b1, 1'b0, 3'b000, 5'd4);
        issue(0, 32'h21, 32'h0, 1'b0, 1'b1, 3'b000, 5'd5);
        issue(0, 32'h21, 32'h0, 1'b0, 1'b1, 3'b100, 5'd6);
        issue(0, 32'h20, 32'h0, 1'b0, 1'b1, 3'b010, 5'd7);
        issue(0, 32'h22, 32'h0, 1'b0, 1'b1, 3'b001, 5'd8);
        issue(0, 32'h20, 32'h0, 1'b0, 1'b1, 3'b101, 5'd9);
        issue(0, 32'h00001234, 32'h0, 1'b0, 1'b0, 3'b010, 5'd10);
        issue(0, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 3'b010, 5'd11);
        issue(0, 32'h1000, 32'h0, 1'b0, 1'b1, 3'b010, 5'd12);
        issue(0, 32'h30, 32'h11223344, 1'b1, 1'b0, 3'b010, 5'd13);
        issue(0, 32'h31, 32'h0000BEEF, 1'b1, 1'b0, 3'b001, 5'd14);
        issue(0, 32'h30, 32'h0, 1'b0, 1'b1, 3'b010, 5'd15);
        issue(0, 32'h50, 32'h5555AAAA, 1'b1, 1'b1, 3'b010, 5'd16);
        issue(0, 32'h50, 32'h0, 1'b0, 1'b1, 3'b010, 5'd17);
        drain(0);

        // Three wait states: stall profile, then a non-memory op right behind.
        issue(1, 32'h40, 32'hAAAA5555, 1'b1, 1'b0, 3'b010, 5'd18);
        issue(1, 32'h40, 32'h0, 1'b0, 1'b1, 3'b010, 5'd19);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ws3_stall_c%0d", i), 32'(st[1]), 32'd1);
            @(posedge clk); #1;
        end
        check("ws3_stall_end", 32'(st[1]), 32'd0);
        issue(1, 32'h00000ABC, 32'h0, 1'b0, 1'b0, 3'b000, 5'd20);
        check("ws3_nonmem_stall", 32'(st[1]), 32'd0);
        drain(1);

        // Flush in the second busy cycle kills the store.
        @(posedge clk); #1;
        vin[1] = 1'b1; addr[1] = 32'h40; wd[1] = 32'h12345678; mw[1] = 1'b1; f3[1] = 3'b010;
        @(posedge clk); #1;
        idle_inputs(1);
        check("flush_busy1_stall", 32'(st[1]), 32'd1);
        @(posedge clk); #1;
        fl[1] = 1'b1;
        check("flush_busy2_stall", 32'(st[1]), 32'd1);
        @(posedge clk); #1;
        fl[1] = 1'b0;
        check("flush_stall_drop", 32'(st[1]), 32'd0);
        check("flush_no_valid", 32'(vo[1]), 32'd0);
        repeat (5) @(posedge clk);
        #1;

        // Flush in idle drops the request outright.
        vin[1] = 1'b1; fl[1] = 1'b1; addr[1] = 32'h40; wd[1] = 32'hDEAD0000; mw[1] = 1'b1;
        @(posedge clk); #1;
        idle_inputs(1);
        check("flush_idle_stall", 32'(st[1]), 32'd0);
        issue(1, 32'h40, 32'h0, 1'b0, 1'b1, 3'b010, 5'd21);
        drain(1);

        // Asynchronous reset mid-busy clears everything at once.
        issue(1, 32'h40, 32'h0, 1'b0, 1'b1, 3'b010, 5'd22);
        @(posedge clk); #1;
        check("pre_reset_stall", 32'(st[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(1, "midrst1");
        check_reset_outputs(0, "midrst0");
        q1.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(1, 32'h40, 32'h0, 1'b0, 1'b1, 3'b010, 5'd23);
        drain(1);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
